// File: rtl/cpc_sync_shaper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpc_video_pkg
// Description : Shared types and default timing constants for the CPC
//               sync shaper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpc_video_pkg;

   typedef enum logic [1:0] {
      HS_IDLE  = 2'd0,
      HS_DELAY = 2'd1,
      HS_PULSE = 2'd2
   } hs_state_t;

   localparam int unsigned DEF_HS_DELAY = 2;
   localparam int unsigned DEF_HS_WIDTH = 4;
   localparam int unsigned DEF_VS_LINES = 2;

   typedef logic [2:0] colour_t;

   // Counters hold at their limit instead of wrapping.
   function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] limit);
      return (value >= limit) ? value : value + 4'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cpc_sync_shaper_if.sv
`default_nettype none
// ============================================================================
// Module      : cpc_sync_shaper_if
// Description : CRTC/palette inputs and shaped video outputs of the sync
//               shaper. CPC_SYNC_SHAPER_LINECOUNT_EN adds line_count.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpc_sync_shaper_if;
   import cpc_video_pkg::*;

   logic    cclk_en;
   logic    crtc_hsync;
   logic    crtc_vsync;
   logic    crtc_de;
   colour_t ri, gi, bi;
   colour_t ro, go, bo;
   logic    hsync_n;
   logic    vsync_n;
   logic    csync_n;
`ifdef CPC_SYNC_SHAPER_LINECOUNT_EN
   logic [8:0] line_count;
`endif

   modport master (
      output cclk_en, crtc_hsync, crtc_vsync, crtc_de, ri, gi, bi,
`ifdef CPC_SYNC_SHAPER_LINECOUNT_EN
      input  line_count,
`endif
      input  ro, go, bo, hsync_n, vsync_n, csync_n
   );

   modport slave (
      input  cclk_en, crtc_hsync, crtc_vsync, crtc_de, ri, gi, bi,
`ifdef CPC_SYNC_SHAPER_LINECOUNT_EN
      output line_count,
`endif
      output ro, go, bo, hsync_n, vsync_n, csync_n
   );

endinterface
`default_nettype wire

// File: rtl/cpc_sync_shaper_timer.sv
`default_nettype none
// ============================================================================
// Module      : sync_pulse_timer
// Description : Delay-then-width pulse FSM counted in cclk_en strobes; the
//               trigger level is sampled only on strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_pulse_timer
   import cpc_video_pkg::*;
#(
   parameter int unsigned DELAY = DEF_HS_DELAY,
   parameter int unsigned WIDTH = DEF_HS_WIDTH
) (
   input  wire  clkvideo,
   input  wire  rst_n,
   input  wire  i_cclk_en,
   input  wire  i_trig,
   output logic o_pulse_nxt,
   output logic o_pulse,
   output logic o_start
);

   localparam logic [3:0] c_delay = 4'(DELAY);
   localparam logic [3:0] c_width = 4'(WIDTH);

   hs_state_t  r_state, w_state_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic       r_trig_q;
   logic       r_pulse;
   logic       w_rise;

   assign w_rise = i_cclk_en & i_trig & ~r_trig_q;

   always_ff @(posedge clkvideo or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= HS_IDLE;
         r_cnt    <= 4'd0;
         r_trig_q <= 1'b0;
         r_pulse  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pulse <= o_pulse_nxt;
         if (i_cclk_en) r_trig_q <= i_trig;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_start     = 1'b0;
      case (r_state)
         HS_IDLE: begin
            if (w_rise) begin
               w_state_nxt = HS_DELAY;
               w_cnt_nxt   = 4'd0;
            end
         end
         HS_DELAY: begin
            // A trigger that drops before the delay expires yields no pulse.
            if (i_cclk_en) begin
               if (!i_trig) begin
                  w_state_nxt = HS_IDLE;
                  w_cnt_nxt   = 4'd0;
               end else if (sat_inc4(r_cnt, c_delay) == c_delay) begin
                  w_state_nxt = HS_PULSE;
                  w_cnt_nxt   = 4'd0;
                  o_start     = 1'b1;
               end else begin
                  w_cnt_nxt = sat_inc4(r_cnt, c_delay);
               end
            end
         end
         HS_PULSE: begin
            if (i_cclk_en) begin
               if (!i_trig || (sat_inc4(r_cnt, c_width) == c_width)) begin
                  w_state_nxt = HS_IDLE;
                  w_cnt_nxt   = 4'd0;
               end else begin
                  w_cnt_nxt = sat_inc4(r_cnt, c_width);
               end
            end
         end
         default: begin
            w_state_nxt = HS_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   assign o_pulse_nxt = (w_state_nxt == HS_PULSE);
   assign o_pulse     = r_pulse;

endmodule
`default_nettype wire

// File: rtl/cpc_sync_shaper.sv
`default_nettype none
// ============================================================================
// Module      : cpc_sync_shaper
// Description : Shapes CRTC sync/DE into monitor sync pulses and blanked RGB.
//               CPC_SYNC_SHAPER_LINECOUNT_EN adds a saturating line counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cpc_sync_shaper
   import cpc_video_pkg::*;
#(
   parameter int unsigned HS_DELAY = DEF_HS_DELAY,
   parameter int unsigned HS_WIDTH = DEF_HS_WIDTH,
   parameter int unsigned VS_LINES = DEF_VS_LINES
) (
   input wire               clkvideo,
   input wire               rst_n,
   cpc_sync_shaper_if.slave bus
);

   localparam logic [3:0] c_vs_lines = 4'(VS_LINES);

   logic       w_hs, w_hs_nxt, w_hs_start;
   logic       w_vs_rise, w_vs_nxt, w_blank;
   logic [3:0] w_vs_cnt_nxt;
   logic       r_vsync_q, r_de_q, r_vs;
   logic [3:0] r_vs_cnt;
   logic       r_hsync_n, r_vsync_n, r_csync_n;
   colour_t    r_ro, r_go, r_bo;

   sync_pulse_timer #(
      .DELAY (HS_DELAY),
      .WIDTH (HS_WIDTH)
   ) u_hs_timer (
      .clkvideo    (clkvideo),
      .rst_n       (rst_n),
      .i_cclk_en   (bus.cclk_en),
      .i_trig      (bus.crtc_hsync),
      .o_pulse_nxt (w_hs_nxt),
      .o_pulse     (w_hs),
      .o_start     (w_hs_start)
   );

   assign w_vs_rise = bus.cclk_en & bus.crtc_vsync & ~r_vsync_q;

   // A VSYNC rise on the same strobe as an hs start takes priority.
   always_comb begin
      w_vs_nxt     = r_vs;
      w_vs_cnt_nxt = r_vs_cnt;
      if (w_vs_rise) begin
         w_vs_nxt     = 1'b1;
         w_vs_cnt_nxt = 4'd0;
      end else if (w_hs_start) begin
         w_vs_cnt_nxt = sat_inc4(r_vs_cnt, c_vs_lines);
         if (r_vs && (w_vs_cnt_nxt == c_vs_lines)) w_vs_nxt = 1'b0;
      end
   end

   assign w_blank = ~r_de_q | w_hs | r_vs;

   always_ff @(posedge clkvideo or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_q <= 1'b0;
         r_de_q    <= 1'b0;
         r_vs      <= 1'b0;
         r_vs_cnt  <= 4'd0;
         r_hsync_n <= 1'b1;
         r_vsync_n <= 1'b1;
         r_csync_n <= 1'b1;
         r_ro      <= '0;
         r_go      <= '0;
         r_bo      <= '0;
      end else begin
         if (bus.cclk_en) begin
            r_vsync_q <= bus.crtc_vsync;
            r_de_q    <= bus.crtc_de;
         end
         r_vs      <= w_vs_nxt;
         r_vs_cnt  <= w_vs_cnt_nxt;
         r_hsync_n <= ~w_hs_nxt;
         r_vsync_n <= ~w_vs_nxt;
         r_csync_n <= ~(w_hs_nxt ^ w_vs_nxt);
         r_ro      <= w_blank ? '0 : bus.ri;
         r_go      <= w_blank ? '0 : bus.gi;
         r_bo      <= w_blank ? '0 : bus.bi;
      end
   end

   assign bus.hsync_n = r_hsync_n;
   assign bus.vsync_n = r_vsync_n;
   assign bus.csync_n = r_csync_n;
   assign bus.ro      = r_ro;
   assign bus.go      = r_go;
   assign bus.bo      = r_bo;

`ifdef CPC_SYNC_SHAPER_LINECOUNT_EN
   logic [8:0] r_line_count;

   always_ff @(posedge clkvideo or negedge rst_n) begin
      if (!rst_n) begin
         r_line_count <= 9'd0;
      end else if (w_vs_rise) begin
         r_line_count <= 9'd0;
      end else if (w_hs_start && (r_line_count != 9'd511)) begin
         r_line_count <= r_line_count + 9'd1;
      end
   end

   assign bus.line_count = r_line_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpc_sync_shaper.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpc_sync_shaper
// Description : Self-checking bench for cpc_sync_shaper, strobe every 16 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpc_sync_shaper;

   typedef struct packed {
      logic hsync_n;
      logic vsync_n;
      logic csync_n;
   } sync_t;

   typedef struct {
      int w;
      int exp_width;
   } hs_vec_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic cur_blank;
   sync_t      sync_q[$];
   logic [8:0] rgb_q[$];

   cpc_sync_shaper_if bus();

   cpc_sync_shaper dut (
      .clkvideo (clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One character-clock period: strobe on the first of 16 clocks, random colour every clock.
   task automatic step(input logic hs_in, input logic vs_in, input logic de_in,
                       input logic exp_hs, input logic exp_vs);
      sync_t      e;
      sync_t      got_e;
      logic [8:0] col;
      e.hsync_n = ~exp_hs;
      e.vsync_n = ~exp_vs;
      e.csync_n = ~(exp_hs ^ exp_vs);
      sync_q.push_back(e);
      for (int j = 0; j < 16; j++) begin
         bus.cclk_en = (j == 0);
         if (j == 0) begin
            bus.crtc_hsync = hs_in;
            bus.crtc_vsync = vs_in;
            bus.crtc_de    = de_in;
         end
         col = 9'($urandom);
         {bus.ri, bus.gi, bus.bi} = col;
         rgb_q.push_back(cur_blank ? 9'd0 : col);
         @(posedge clk);
         if (j == 0) cur_blank = ~de_in | exp_hs | exp_vs;
         @(negedge clk);
         chk("rgb", 32'({bus.ro, bus.go, bus.bo}), 32'(rgb_q.pop_front()));
         if (j == 0) got_e = sync_q.pop_front();
         if (j == 0 || j == 15)
            chk("sync", 32'({bus.hsync_n, bus.vsync_n, bus.csync_n}), 32'(got_e));
      end
   endtask

   task automatic check_idle_outputs(input string name);
      chk(name, 32'({bus.hsync_n, bus.vsync_n, bus.csync_n, bus.ro, bus.go, bus.bo}),
          32'({3'b111, 9'd0}));
   endtask

   hs_vec_t hs_tab[6];

   initial begin
      int s;
      int pos;
      checks = 0;
      errors = 0;
      cur_blank = 1'b1;
      hs_tab[0] = '{14, 4};
      hs_tab[1] = '{5, 3};
      hs_tab[2] = '{2, 0};
      hs_tab[3] = '{3, 1};
      hs_tab[4] = '{6, 4};
      hs_tab[5] = '{1, 0};

      rst_n = 1'b0;
      bus.cclk_en = 1'b0;
      bus.crtc_hsync = 1'b0;
      bus.crtc_vsync = 1'b0;
      bus.crtc_de = 1'b0;
      {bus.ri, bus.gi, bus.bi} = 9'h1FF;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;

      // DE on, no sync: colours pass with one clock of latency.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // 5/2/7 fixed colour, DE on.
      {bus.ri, bus.gi, bus.bi} = {3'd5, 3'd2, 3'd7};
      @(posedge clk);
      @(negedge clk);
      chk("rgb_527", 32'({bus.ro, bus.go, bus.bo}), 32'({3'd5, 3'd2, 3'd7}));

      // HSYNC width table: pulse at strobes [2, 2+exp_width).
      foreach (hs_tab[t]) begin
         for (int k = 0; k < hs_tab[t].w + 4; k++)
            step(k < hs_tab[t].w, 1'b0, 1'b1,
                 (k >= 2) && (k < 2 + hs_tab[t].exp_width), 1'b0);
      end

      // DE drop blanks after the next strobe, then comes back.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // 20-strobe lines, CRTC HSYNC 14 wide; two VSYNC rises, the second coinciding with an hs start.
      for (s = 0; s < 140; s++) begin
         pos = s % 20;
         step(pos < 14,
              ((s >= 28) && (s < 68)) || ((s >= 82) && (s < 92)),
              1'b1,
              (pos >= 2) && (pos < 6),
              ((s >= 28) && (s < 62)) || ((s >= 82) && (s < 122)));
      end

      // Reset during the pulse forces idle outputs immediately.
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      bus.cclk_en = 1'b1;
      bus.crtc_hsync = 1'b1;
      @(posedge clk);
      #2;
      bus.cclk_en = 1'b0;
      chk("hs_before_reset", 32'(bus.hsync_n), 32'd0);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("async_reset");
      bus.crtc_hsync = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cur_blank = 1'b1;
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) step(k < 5, 1'b0, 1'b1, (k >= 2) && (k < 5), 1'b0);

`ifdef CPC_SYNC_SHAPER_LINECOUNT_EN
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("line_count_clear", 32'(bus.line_count), 32'd0);
      for (int i = 0; i < 600; i++) begin
         for (int p = 0; p < 4; p++)
            step(p < 3, 1'b0, 1'b1, p == 2, (i == 0) || ((i == 1) && (p < 2)));
      end
      chk("line_count_sat", 32'(bus.line_count), 32'd511);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("line_count_reclear", 32'(bus.line_count), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
